// File: rtl/case4_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : case4_sweep_ctrl_if
// Brief    : Control, status and stimulus/response bundle for the case4 sweep
//            sequencer. The slave side is the sequencer itself.
// Revision : 1.0  initial release
// ============================================================================
interface case4_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [6:0]  vec_o;
    logic [2:0]  xyz_i;
    logic        busy;
    logic        done;
    logic [7:0]  cnt_x;
    logic [7:0]  cnt_y;
    logic [7:0]  cnt_z;
    logic [15:0] sig;

    modport master (
        output start, abort, xyz_i,
        input  vec_o, busy, done, cnt_x, cnt_y, cnt_z, sig
    );

    modport slave (
        input  start, abort, xyz_i,
        output vec_o, busy, done, cnt_x, cnt_y, cnt_z, sig
    );
endinterface
`default_nettype wire

// File: rtl/case4_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : case4_sweep_ctrl
// Brief    : Drives all 128 vectors onto the case4 logic, samples x/y/z after
//            SETTLE cycles and accumulates one-counts and a 16-bit MISR.
// Revision : 1.0  initial release
// ============================================================================
module case4_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    case4_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  c_reload   = 4'(SETTLE - 1);
    localparam logic [15:0] c_poly     = 16'h1021;
    localparam logic [6:0]  c_last_vec = 7'd127;

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_vec, w_vec_nxt;
    logic [3:0]  r_timer, w_timer_nxt;
    logic [7:0]  r_cnt_x, w_cnt_x_nxt;
    logic [7:0]  r_cnt_y, w_cnt_y_nxt;
    logic [7:0]  r_cnt_z, w_cnt_z_nxt;
    logic [15:0] r_sig, w_sig_nxt;
    logic [15:0] w_sig_step;
    logic        r_busy;
    logic        r_done;

    assign w_sig_step = {r_sig[14:0], 1'b0}
                      ^ (r_sig[15] ? c_poly : 16'h0000)
                      ^ {13'd0, bus.xyz_i};

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_timer_nxt = r_timer;
        w_cnt_x_nxt = r_cnt_x;
        w_cnt_y_nxt = r_cnt_y;
        w_cnt_z_nxt = r_cnt_z;
        w_sig_nxt   = r_sig;

        unique case (r_state)
            ST_IDLE: begin
                // abort has priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    w_state_nxt = ST_WAIT;
                    w_vec_nxt   = 7'd0;
                    w_timer_nxt = c_reload;
                    w_cnt_x_nxt = 8'd0;
                    w_cnt_y_nxt = 8'd0;
                    w_cnt_z_nxt = 8'd0;
                    w_sig_nxt   = 16'h0000;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_vec_nxt   = 7'd0;
                end else if (r_timer == 4'd0) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_timer_nxt = r_timer - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_vec_nxt   = 7'd0;
                end else begin
                    w_cnt_x_nxt = r_cnt_x + {7'd0, bus.xyz_i[2]};
                    w_cnt_y_nxt = r_cnt_y + {7'd0, bus.xyz_i[1]};
                    w_cnt_z_nxt = r_cnt_z + {7'd0, bus.xyz_i[0]};
                    w_sig_nxt   = w_sig_step;
                    if (r_vec == c_last_vec) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_vec_nxt   = r_vec + 7'd1;
                        w_timer_nxt = c_reload;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_vec_nxt   = 7'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= 7'd0;
            r_timer <= 4'd0;
            r_cnt_x <= 8'd0;
            r_cnt_y <= 8'd0;
            r_cnt_z <= 8'd0;
            r_sig   <= 16'h0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_timer <= w_timer_nxt;
            r_cnt_x <= w_cnt_x_nxt;
            r_cnt_y <= w_cnt_y_nxt;
            r_cnt_z <= w_cnt_z_nxt;
            r_sig   <= w_sig_nxt;
            r_busy  <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_SAMPLE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.vec_o = r_vec;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.cnt_x = r_cnt_x;
    assign bus.cnt_y = r_cnt_y;
    assign bus.cnt_z = r_cnt_z;
    assign bus.sig   = r_sig;

endmodule
`default_nettype wire
